// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The optional bypass path is enabled by defining RF_WB_BYPASS_EN.
package rf_wb_pkg;

    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int NREGS   = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] data_word_t;

    // Round-robin successor of a grant index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Round-robin grant selection: the search starts at ptr_i and wraps modulo N.
// Pure combinational; the pointer itself lives in the parent.
module rf_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] gidx_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan requesters from ptr_i upward; the first valid one wins.
    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        any_o   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any_o && valid_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                gidx_o       = idx;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Round-robin arbitration over NUM_REQ sources, one registered write per
// cycle to the regfile, per-register pending counters for hazard checks.
// Optional same-cycle bypass of the registered write: RF_WB_BYPASS_EN.
//
// Handshake: requester i transfers when req_valid[i] & req_ready[i] are both
// high on a rising clk edge; req_ready never depends on the register port
// being free (there is no backpressure), only on arbitration and reset.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = rf_wb_pkg::AW,
    parameter int DW      = rf_wb_pkg::DW,
    parameter int CNT_W   = rf_wb_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_waddr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    output logic                  alloc_ready,
    input  logic [AW-1:0]         chk_addr1,
    input  logic [AW-1:0]         chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DW-1:0]         fwd_data1,
    output logic [DW-1:0]         fwd_data2,
    output logic                  sb_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NR = 1 << AW;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               any_grant;
    logic               hs;
    logic [AW-1:0]      g_addr;
    logic [DW-1:0]      g_data;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic               rf_we_q;
    logic [AW-1:0]      rf_waddr_q;
    logic [DW-1:0]      rf_wdata_q;

    logic [CNT_W-1:0]   cnt_q [NR];
    logic [CNT_W-1:0]   cnt_d [NR];
    logic               sb_err_q, sb_err_d;
    logic               alloc_fire;

    rf_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .gidx_o  (gidx),
        .any_o   (any_grant)
    );

    // Grants are masked while reset is held so nothing transfers.
    assign req_ready = reset ? '0 : grant;
    assign hs        = any_grant & ~reset;
    assign g_addr    = req_waddr[gidx*AW +: AW];
    assign g_data    = req_wdata[gidx*DW +: DW];

    // Pointer advances past the winner only when a transfer happens.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = IW'(rr_next(int'(gidx), NUM_REQ));
        end
    end

    // Pointer and registered regfile write; writes to r0 are swallowed here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= hs && (g_addr != '0);
            if (hs) begin
                rf_waddr_q <= g_addr;
                rf_wdata_q <= g_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // A saturated counter stalls further reservations of that register.
    assign alloc_ready = (alloc_addr == '0) || (cnt_q[alloc_addr] != CNT_SAT);
    assign alloc_fire  = alloc_valid && alloc_ready && (alloc_addr != '0);

    // Scoreboard next state: reserve increments, commit decrements, both cancel.
    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (alloc_fire && !(rf_we_q && (rf_waddr_q == alloc_addr))) begin
            cnt_d[alloc_addr] = cnt_q[alloc_addr] + CNT_W'(1);
        end
        if (rf_we_q && !(alloc_fire && (alloc_addr == rf_waddr_q))) begin
            if (cnt_q[rf_waddr_q] == '0) begin
                sb_err_d = 1'b1;
            end else begin
                cnt_d[rf_waddr_q] = cnt_q[rf_waddr_q] - CNT_W'(1);
            end
        end
    end

    // Scoreboard state; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    // Busy reflects stored state; a commit in flight this cycle still counts.
    assign chk_busy1 = (chk_addr1 != '0) && (cnt_q[chk_addr1] != '0);
    assign chk_busy2 = (chk_addr2 != '0) && (cnt_q[chk_addr2] != '0);

`ifdef RF_WB_BYPASS_EN
    // Readers get the value being written this cycle; the regfile still holds old data.
    assign fwd_hit1  = rf_we_q && (rf_waddr_q == chk_addr1) && (chk_addr1 != '0);
    assign fwd_hit2  = rf_we_q && (rf_waddr_q == chk_addr2) && (chk_addr2 != '0);
    assign fwd_data1 = rf_wdata_q;
    assign fwd_data2 = rf_wdata_q;
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration and the scoreboard.
module tb_rf_wb_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int CNT_MAX = 3;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_waddr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic                  rf_we;
    logic [AW-1:0]         rf_waddr;
    logic [DW-1:0]         rf_wdata;
    logic                  alloc_valid;
    logic [AW-1:0]         alloc_addr;
    logic                  alloc_ready;
    logic [AW-1:0]         chk_addr1, chk_addr2;
    logic                  chk_busy1, chk_busy2;
    logic                  fwd_hit1, fwd_hit2;
    logic [DW-1:0]         fwd_data1, fwd_data2;
    logic                  sb_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int          m_cnt [32];
    int          m_ptr;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;

    rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .sb_err(sb_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = '0; m_err = 0;
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] m_ready();
        logic [NUM_REQ-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic bit m_alloc_ready();
        return (alloc_addr == 0) || (m_cnt[alloc_addr] != CNT_MAX);
    endfunction

    function automatic bit m_busy(input int a);
        return (a != 0) && (m_cnt[a] != 0);
    endfunction

    function automatic bit m_fwd(input int a);
        return BYPASS && m_we && (m_waddr == a) && (a != 0);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void m_tick();
        int g;
        int a;
        bit inc;
        g   = m_grant();
        a   = int'(alloc_addr);
        inc = alloc_valid && m_alloc_ready() && (a != 0);
        if (m_we) begin
            if (inc && a == m_waddr) inc = 0;
            else if (m_cnt[m_waddr] == 0) m_err = 1;
            else m_cnt[m_waddr] = m_cnt[m_waddr] - 1;
        end
        if (inc) m_cnt[a] = m_cnt[a] + 1;
        if (g >= 0) begin
            m_waddr = int'(req_waddr[g*AW +: AW]);
            m_wdata = req_wdata[g*DW +: DW];
            m_we    = (m_waddr != 0);
            m_ptr   = (g + 1) % NUM_REQ;
        end else begin
            m_we = 0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req_valid = '0; req_waddr = '0; req_wdata = '0;
        alloc_valid = 1'b0; alloc_addr = '0;
        chk_addr1 = '0; chk_addr2 = '0;
    endtask

    task automatic clk_step();
        m_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rst_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) $display("FAIL rst_wr: got %0h/%0h expected 0/0", rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (sb_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", sb_err); else n_pass++;
        // reserve r3 and launch a write so one is in flight
        alloc_valid = 1'b1; alloc_addr = 5'd3; chk_addr1 = 5'd3;
        req_valid = 2'b01; req_waddr[4:0] = 5'd3; req_wdata[31:0] = 32'hA5A5A5A5;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL rst_hs: got %b expected 01", req_ready); else n_pass++;
        clk_step();
        alloc_valid = 1'b0;
        n_checks++; if (rf_we !== 1'b1 || chk_busy1 !== 1'b1) $display("FAIL rst_due: got we=%b busy=%b expected 1/1", rf_we, chk_busy1); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rst_drop: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", req_ready); else n_pass++;
        n_checks++; if (chk_busy1 !== 1'b0 || sb_err !== 1'b0) $display("FAIL rst_sb: got busy=%b err=%b expected 0/0", chk_busy1, sb_err); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = '0;
        m_reset();
        #1;
        n_checks++; if (rf_we !== 1'b0 || sb_err !== 1'b0) $display("FAIL rst_after: got we=%b err=%b expected 0/0", rf_we, sb_err); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready;
        logic [4:0] exp_addr;
        apply_reset();
        req_valid = 2'b11;
        req_waddr = {5'd4, 5'd3};
        req_wdata = {32'h4444_0004, 32'h3333_0003};
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (req_ready !== exp_ready) $display("FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp_ready); else n_pass++;
            if (i > 0) begin
                exp_addr = ((i - 1) % 2 == 0) ? 5'd3 : 5'd4;
                n_checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr) $display("FAIL rr_waddr%0d: got we=%b addr=%0d expected 1/%0d", i, rf_we, rf_waddr, exp_addr); else n_pass++;
            end
            clk_step();
        end
        req_valid = '0;
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h4444_0004) $display("FAIL rr_last: got we=%b addr=%0d data=%h expected 1/4/44440004", rf_we, rf_waddr, rf_wdata); else n_pass++;
        clk_step();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rr_idle: got %b expected 0", rf_we); else n_pass++;
    endtask

    task automatic test_alloc_saturate();
        apply_reset();
        alloc_valid = 1'b1; alloc_addr = 5'd5; chk_addr1 = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (alloc_ready !== 1'b1) $display("FAIL sat_alloc%0d: got %b expected 1", i, alloc_ready); else n_pass++;
            clk_step();
        end
        n_checks++; if (chk_busy1 !== 1'b1) $display("FAIL sat_busy: got %b expected 1", chk_busy1); else n_pass++;
        n_checks++; if (alloc_ready !== 1'b0) $display("FAIL sat_full: got %b expected 0", alloc_ready); else n_pass++;
        clk_step();
        alloc_valid = 1'b0;
        req_valid = 2'b01; req_waddr[4:0] = 5'd5; req_wdata[31:0] = 32'h0000_0055;
        clk_step();
        req_valid = '0;
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        #1;
        n_checks++; if (rf_we !== 1'b1 || alloc_ready !== 1'b0) $display("FAIL sat_commit: got we=%b ready=%b expected 1/0", rf_we, alloc_ready); else n_pass++;
        clk_step();
        alloc_valid = 1'b0;
        #1;
        n_checks++; if (alloc_ready !== 1'b1 || chk_busy1 !== 1'b1) $display("FAIL sat_free: got ready=%b busy=%b expected 1/1", alloc_ready, chk_busy1); else n_pass++;
        n_checks++; if (sb_err !== 1'b0) $display("FAIL sat_err: got %b expected 0", sb_err); else n_pass++;
    endtask

    task automatic test_alloc_commit_same();
        apply_reset();
        alloc_valid = 1'b1; alloc_addr = 5'd7; chk_addr1 = 5'd7;
        clk_step();
        alloc_valid = 1'b0;
        req_valid = 2'b01; req_waddr[4:0] = 5'd7; req_wdata[31:0] = 32'h0000_0077;
        clk_step();
        req_valid = '0;
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || alloc_ready !== 1'b1) $display("FAIL same_setup: got we=%b addr=%0d ready=%b expected 1/7/1", rf_we, rf_waddr, alloc_ready); else n_pass++;
        clk_step();
        alloc_valid = 1'b0;
        n_checks++; if (chk_busy1 !== 1'b1 || sb_err !== 1'b0) $display("FAIL same_net: got busy=%b err=%b expected 1/0", chk_busy1, sb_err); else n_pass++;
        // a single further commit must drain r7 exactly to zero
        req_valid = 2'b01;
        clk_step();
        req_valid = '0;
        clk_step();
        n_checks++; if (chk_busy1 !== 1'b0 || sb_err !== 1'b0) $display("FAIL same_drain: got busy=%b err=%b expected 0/0", chk_busy1, sb_err); else n_pass++;
    endtask

    task automatic test_r0_and_sberr();
        apply_reset();
        alloc_valid = 1'b1; alloc_addr = 5'd2; chk_addr1 = 5'd2;
        clk_step();
        alloc_valid = 1'b0;
        req_valid = 2'b01; req_waddr[4:0] = 5'd0; req_wdata[31:0] = 32'hDEADBEEF;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL r0_ready: got %b expected 01", req_ready); else n_pass++;
        clk_step();
        req_valid = '0;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL r0_we: got %b expected 0", rf_we); else n_pass++;
        clk_step();
        n_checks++; if (chk_busy1 !== 1'b1 || sb_err !== 1'b0) $display("FAIL r0_sb: got busy=%b err=%b expected 1/0", chk_busy1, sb_err); else n_pass++;
        req_valid = 2'b11; req_waddr = {5'd9, 5'd9}; req_wdata = {32'h9, 32'h9};
        clk_step();
        req_valid = '0;
        n_checks++; if (sb_err !== 1'b0) $display("FAIL err_early: got %b expected 0", sb_err); else n_pass++;
        clk_step();
        n_checks++; if (sb_err !== 1'b1) $display("FAIL err_set: got %b expected 1", sb_err); else n_pass++;
        repeat (3) clk_step();
        n_checks++; if (sb_err !== 1'b1) $display("FAIL err_hold: got %b expected 1", sb_err); else n_pass++;
        apply_reset();
        #1;
        n_checks++; if (sb_err !== 1'b0) $display("FAIL err_clear: got %b expected 0", sb_err); else n_pass++;
    endtask

    task automatic test_bypass();
        logic        exp_hit;
        logic [31:0] exp_data;
        apply_reset();
        req_valid = 2'b01; req_waddr[4:0] = 5'd8; req_wdata[31:0] = 32'h12345678;
        clk_step();
        req_valid = '0;
        chk_addr1 = 5'd8; chk_addr2 = 5'd3;
        #1;
        exp_hit  = BYPASS;
        exp_data = BYPASS ? 32'h12345678 : 32'h0;
        n_checks++; if (fwd_hit1 !== exp_hit || fwd_data1 !== exp_data) $display("FAIL byp_hit1: got %b/%h expected %b/%h", fwd_hit1, fwd_data1, exp_hit, exp_data); else n_pass++;
        n_checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== exp_data) $display("FAIL byp_miss2: got %b/%h expected 0/%h", fwd_hit2, fwd_data2, exp_data); else n_pass++;
        clk_step();
        n_checks++; if (fwd_hit1 !== 1'b0) $display("FAIL byp_after: got %b expected 0", fwd_hit1); else n_pass++;
    endtask

    task automatic test_random();
        int fails_before;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < NUM_REQ; i++) begin
                req_waddr[i*AW +: AW] = 5'($urandom_range(0, 7));
                req_wdata[i*DW +: DW] = $urandom;
            end
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_addr  = 5'($urandom_range(0, 7));
            chk_addr1   = 5'($urandom_range(0, 7));
            chk_addr2   = 5'($urandom_range(0, 7));
            #1;
            fails_before = n_checks - n_pass;
            n_checks++; if (req_ready !== m_ready()) $display("FAIL rnd_ready c%0d: got %b expected %b", c, req_ready, m_ready()); else n_pass++;
            n_checks++; if (alloc_ready !== m_alloc_ready()) $display("FAIL rnd_alloc c%0d: got %b expected %b", c, alloc_ready, m_alloc_ready()); else n_pass++;
            n_checks++; if (chk_busy1 !== m_busy(int'(chk_addr1)) || chk_busy2 !== m_busy(int'(chk_addr2))) $display("FAIL rnd_busy c%0d: got %b%b expected %b%b", c, chk_busy1, chk_busy2, m_busy(int'(chk_addr1)), m_busy(int'(chk_addr2))); else n_pass++;
            n_checks++; if (rf_we !== m_we) $display("FAIL rnd_we c%0d: got %b expected %b", c, rf_we, m_we); else n_pass++;
            if (m_we) begin
                n_checks++; if (rf_waddr !== 5'(m_waddr) || rf_wdata !== m_wdata) $display("FAIL rnd_wr c%0d: got %0d/%h expected %0d/%h", c, rf_waddr, rf_wdata, m_waddr, m_wdata); else n_pass++;
            end
            n_checks++; if (sb_err !== m_err) $display("FAIL rnd_err c%0d: got %b expected %b", c, sb_err, m_err); else n_pass++;
            n_checks++; if (fwd_hit1 !== m_fwd(int'(chk_addr1)) || fwd_data1 !== (BYPASS ? m_wdata : 32'h0)) $display("FAIL rnd_fwd c%0d: got %b/%h expected %b/%h", c, fwd_hit1, fwd_data1, m_fwd(int'(chk_addr1)), BYPASS ? m_wdata : 32'h0); else n_pass++;
            // stop early once the model and design have diverged
            if (n_checks - n_pass > fails_before + 3) break;
            clk_step();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_alloc_saturate();
        test_alloc_commit_same();
        test_r0_and_sberr();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
